// File: rtl/core_run_pkg.sv
// rtl/core_run_pkg.sv - shared state and result encodings for the core run sequencer
package core_run_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DRAIN} run_state_e;

  typedef enum logic [1:0] {
    FAIL_NONE,
    FAIL_TIMEOUT,
    FAIL_MISMATCH,
    FAIL_ABORT
  } fail_code_e;

endpackage

// File: rtl/core_run_timer.sv
// rtl/core_run_timer.sv - loadable down-counter, stops at zero, flags zero
module core_run_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run sequencer: holds core in reset, runs it, grades the result
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned TIMEOUT      = 100,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_expect_cycles,
  input  logic             i_core_done,
  output logic             o_core_reset_l,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [1:0]       o_fail_code,
  output logic [CNT_W-1:0] o_run_cycles
);

  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_RUN   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_DRAIN = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  run_state_e       r_state;
  fail_code_e       r_fail;
  logic             r_core_reset_l;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_expect;
  logic [CNT_W-1:0] r_run_cycles;

  logic             w_tmr_load;
  logic             w_tmr_en;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic             w_run_exit;
  logic             w_match;

  assign w_run_exit = i_core_done || w_tmr_zero;
  assign w_match    = (r_run_cycles == r_expect);

  // The one timer is reloaded on every state entry: hold length, watchdog, drain length.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE: begin
        w_tmr_load = i_start && !i_abort;
        w_tmr_val  = LD_HOLD;
      end
      HOLD: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_RUN;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      RUN: begin
        if (w_run_exit) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_DRAIN;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      DRAIN:   w_tmr_en = 1'b1;
      default: ;
    endcase
  end

  core_run_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_fail         <= FAIL_NONE;
      r_core_reset_l <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_expect       <= '0;
      r_run_cycles   <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != IDLE) && i_abort) begin
        r_state        <= IDLE;
        r_fail         <= FAIL_ABORT;
        r_pass         <= 1'b0;
        r_done         <= 1'b1;
        r_busy         <= 1'b0;
        r_core_reset_l <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start && !i_abort) begin
              r_state      <= HOLD;
              r_busy       <= 1'b1;
              r_expect     <= i_expect_cycles;
              r_pass       <= 1'b0;
              r_fail       <= FAIL_NONE;
              r_run_cycles <= '0;
            end
          end
          HOLD: begin
            if (w_tmr_zero) begin
              r_state        <= RUN;
              r_core_reset_l <= 1'b1;
            end
          end
          RUN: begin
            // core_done is graded before the watchdog so a finish on the last cycle still counts.
            if (i_core_done) begin
              r_pass <= w_match;
              r_fail <= w_match ? FAIL_NONE : FAIL_MISMATCH;
            end else if (w_tmr_zero) begin
              r_pass <= 1'b0;
              r_fail <= FAIL_TIMEOUT;
            end else if (r_run_cycles != '1) begin
              r_run_cycles <= r_run_cycles + CNT_W'(1);
            end
            if (w_run_exit) begin
              if (DRAIN_CYCLES == 0) begin
                r_state        <= IDLE;
                r_busy         <= 1'b0;
                r_done         <= 1'b1;
                r_core_reset_l <= 1'b0;
              end else begin
                r_state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (w_tmr_zero) begin
              r_state        <= IDLE;
              r_busy         <= 1'b0;
              r_done         <= 1'b1;
              r_core_reset_l <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_core_reset_l = r_core_reset_l;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_pass         = r_pass;
  assign o_fail_code    = r_fail;
  assign o_run_cycles   = r_run_cycles;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - self-checking bench for core_run_ctrl against a timeline model
module tb_core_run_ctrl;

  localparam int CNT_W = 32;
  localparam int R     = 4;
  localparam int TO    = 100;
  localparam int D     = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             core_done = 1'b0;
  logic [CNT_W-1:0] expect_c = '0;
  logic             core_reset_l;
  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] run_cycles;

  int n_checks = 0;
  int n_err    = 0;

  core_run_ctrl #(
    .CNT_W        (CNT_W),
    .RST_CYCLES   (R),
    .TIMEOUT      (TO),
    .DRAIN_CYCLES (D)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_start         (start),
    .i_abort         (abort),
    .i_expect_cycles (expect_c),
    .i_core_done     (core_done),
    .o_core_reset_l  (core_reset_l),
    .o_busy          (busy),
    .o_done          (done),
    .o_pass          (pass),
    .o_fail_code     (fail_code),
    .o_run_cycles    (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k counts cycles since the accepting edge; cycles 1..R hold, then run until m_end, then D drain cycles.
  bit m_active, m_pass, m_done;
  int m_k, m_end, m_rc, m_exp, m_fail, m_c;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_pass = 0; m_done = 0;
      m_k = 0; m_end = 0; m_rc = 0; m_exp = 0; m_fail = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start && !abort) begin
          m_active = 1; m_k = 1; m_end = 0; m_exp = expect_c;
          m_pass = 0; m_fail = 0; m_rc = 0;
        end
      end else if (abort) begin
        m_active = 0; m_fail = 3; m_pass = 0; m_done = 1;
      end else if (m_k <= R) begin
        m_k++;
      end else if (m_end == 0) begin
        m_c = m_k - R - 1;
        if (core_done) begin
          m_pass = (m_c == m_exp);
          m_fail = m_pass ? 0 : 2;
          m_end  = m_k;
        end else if (m_c == TO - 1) begin
          m_pass = 0; m_fail = 1; m_end = m_k;
        end else begin
          m_rc = m_c + 1;
        end
        if (m_end != 0 && D == 0) begin
          m_active = 0; m_done = 1;
        end
        m_k++;
      end else begin
        if (m_k == m_end + D) begin
          m_active = 0; m_done = 1;
        end
        m_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("core_reset_l", 32'(core_reset_l), 32'(m_active && (m_k > R)));
      chk("busy",         32'(busy),         32'(m_active));
      chk("done",         32'(done),         32'(m_done));
      chk("pass",         32'(pass),         32'(m_pass));
      chk("fail_code",    32'(fail_code),    32'(m_fail));
      chk("run_cycles",   run_cycles,        32'(m_rc));
    end
  end

  // Caller is at a negedge; start is raised immediately so it can land in a done cycle.
  task automatic run_case(input int exp_c, input int j_done, input int j_abort,
                          input bit busy_start, output int n_low, output int n_cyc);
    expect_c = exp_c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_low = 0;
    while (!core_reset_l && n_low < 20) begin
      n_low++;
      @(negedge clk);
    end
    n_cyc = 0;
    for (int j = 1; j <= 300; j++) begin
      core_done = (j == j_done);
      abort     = (j == j_abort);
      start     = busy_start;
      @(negedge clk);
      core_done = 1'b0;
      abort     = 1'b0;
      start     = 1'b0;
      n_cyc     = j;
      if (!busy) break;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_core_reset_l"}, 32'(core_reset_l), 0);
    chk({tag, "_rst_busy"},         32'(busy),         0);
    chk({tag, "_rst_done"},         32'(done),         0);
    chk({tag, "_rst_pass"},         32'(pass),         0);
    chk({tag, "_rst_fail_code"},    32'(fail_code),    0);
    chk({tag, "_rst_run_cycles"},   run_cycles,        0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_low, n_cyc;
    @(negedge clk);
    chk_reset_vals("init");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // T1 nominal
    run_case(3, 4, 0, 0, n_low, n_cyc);
    chk("t1_hold_len", n_low, 4);
    chk("t1_cycles",   n_cyc, 6);
    chk("t1_done",     32'(done), 1);
    chk("t1_pass",     32'(pass), 1);
    chk("t1_fail",     32'(fail_code), 0);
    chk("t1_rc",       run_cycles, 3);

    // T2 mismatch, started back-to-back in the done cycle of T1
    run_case(5, 4, 0, 0, n_low, n_cyc);
    chk("t2_hold_len", n_low, 4);
    chk("t2_cycles",   n_cyc, 6);
    chk("t2_pass",     32'(pass), 0);
    chk("t2_fail",     32'(fail_code), 2);
    chk("t2_rc",       run_cycles, 3);
    @(negedge clk);

    // T3 timeout
    run_case(7, 0, 0, 0, n_low, n_cyc);
    chk("t3_cycles", n_cyc, 102);
    chk("t3_done",   32'(done), 1);
    chk("t3_pass",   32'(pass), 0);
    chk("t3_fail",   32'(fail_code), 1);
    chk("t3_rc",     run_cycles, 99);
    @(negedge clk);

    // T4 abort during the third RUN cycle
    run_case(3, 0, 3, 0, n_low, n_cyc);
    chk("t4_cycles",  n_cyc, 3);
    chk("t4_done",    32'(done), 1);
    chk("t4_fail",    32'(fail_code), 3);
    chk("t4_crst",    32'(core_reset_l), 0);
    chk("t4_rc",      run_cycles, 2);
    @(negedge clk);

    // T5 core_done on the timeout cycle
    run_case(99, 100, 0, 0, n_low, n_cyc);
    chk("t5_cycles", n_cyc, 102);
    chk("t5_pass",   32'(pass), 1);
    chk("t5_fail",   32'(fail_code), 0);
    chk("t5_rc",     run_cycles, 99);
    @(negedge clk);

    // T5 start held while busy
    run_case(3, 4, 0, 1, n_low, n_cyc);
    chk("t5b_cycles", n_cyc, 6);
    chk("t5b_pass",   32'(pass), 1);
    @(negedge clk);
    chk("t5b_idle", 32'(busy), 0);

    // T5 start with abort in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t5c_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t5c_busy2", 32'(busy), 0);
    chk("t5c_crst",  32'(core_reset_l), 0);

    // T6 asynchronous reset mid-RUN
    expect_c = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_in_run", 32'(core_reset_l), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("t6");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t6_no_done", 32'(done), 0);
    run_case(3, 4, 0, 0, n_low, n_cyc);
    chk("t6_hold_len", n_low, 4);
    chk("t6_cycles",   n_cyc, 6);
    chk("t6_pass",     32'(pass), 1);
    chk("t6_rc",       run_cycles, 3);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
